// File: rtl/audio_frame_sequencer.sv
// rtl/audio_frame_sequencer.sv - per-sample MIC SPI read followed by DAC SPI write, single clk domain
module audio_frame_sequencer #(
  parameter int CLK_DIV   = 25,
  parameter int FRAME_DIV = 2268
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mic_miso,
  output logic        mic_ss,
  output logic        mic_sck,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FRAME_DIV - 1);

  typedef enum logic [2:0] {IDLE, CAP_SETUP, CAP_SHIFT, GAP, DAC_SHIFT, DONE} state_t;

  state_t        state;
  logic          en_q;
  logic          tick_q;
  logic [FW-1:0] fc;
  logic [HW-1:0] hc;
  logic [3:0]    bc;
  logic          phase;
  logic [11:0]   shift;
  logic [14:0]   dword;
  logic          half_end;

  assign half_end = (hc == HC_LAST);

  // enable is a board-level input, so it is registered before it gates the frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      fc     <= '0;
      tick_q <= 1'b0;
    end else begin
      en_q   <= enable;
      tick_q <= en_q && (fc == FC_LAST);
      if (!en_q || fc == FC_LAST) fc <= '0;
      else                        fc <= fc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hc           <= '0;
      bc           <= '0;
      phase        <= 1'b0;
      shift        <= '0;
      dword        <= '0;
      mic_ss       <= 1'b1;
      mic_sck      <= 1'b1;
      dac_sync     <= 1'b1;
      dac_sclk     <= 1'b1;
      dac_mosi     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      hc <= (state == IDLE || half_end) ? '0 : hc + 1'b1;
      if (tick_q && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick_q) begin
          state   <= CAP_SETUP;
          mic_ss  <= 1'b0;
          mic_sck <= 1'b1;
          busy    <= 1'b1;
        end
        CAP_SETUP: if (half_end) begin
          state   <= CAP_SHIFT;
          mic_sck <= 1'b0;
          phase   <= 1'b0;
          bc      <= '0;
        end
        // only the last 12 bits shifted in survive, which drops the 4 leading pad bits
        CAP_SHIFT: if (half_end) begin
          if (!phase) begin
            mic_sck <= 1'b1;
            shift   <= {shift[10:0], mic_miso};
            phase   <= 1'b1;
          end else if (bc == 4'd15) begin
            state        <= GAP;
            mic_ss       <= 1'b1;
            sample_out   <= shift;
            sample_valid <= 1'b1;
          end else begin
            mic_sck <= 1'b0;
            phase   <= 1'b0;
            bc      <= bc + 4'd1;
          end
        end
        GAP: if (half_end) begin
          state    <= DAC_SHIFT;
          dac_sync <= 1'b0;
          dac_sclk <= 1'b1;
          dac_mosi <= 1'b0;
          dword    <= {3'b000, sample_out};
          phase    <= 1'b0;
          bc       <= '0;
        end
        DAC_SHIFT: if (half_end) begin
          if (!phase) begin
            dac_sclk <= 1'b0;
            phase    <= 1'b1;
          end else if (bc == 4'd15) begin
            state    <= DONE;
            dac_sclk <= 1'b1;
            dac_sync <= 1'b1;
            dac_mosi <= 1'b0;
          end else begin
            dac_sclk <= 1'b1;
            phase    <= 1'b0;
            bc       <= bc + 4'd1;
            dac_mosi <= dword[14];
            dword    <= {dword[13:0], 1'b0};
          end
        end
        DONE: if (half_end) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
